// File: rtl/column_scanner.sv
// Column scanner for a multiplexed display matrix: one-hot or mirrored-pair column drive with
// per-column dwell. Optional macro COLUMN_SCANNER_GHOST_BLANK_EN adds a one-cycle blank between columns.
module column_scanner #(
  parameter int unsigned COLS    = 5,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned PH_W   = (COLS > 2) ? $clog2(COLS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               mirror,
  input  logic [DWELL_W-1:0] dwell,
  output logic [COLS-1:0]    col,
  output logic [PH_W-1:0]    phase,
  output logic               frame_start
);

  localparam int unsigned     HALF     = (COLS + 1) / 2;
  localparam logic [PH_W-1:0] LastFull = PH_W'(COLS - 1);
  localparam logic [PH_W-1:0] LastHalf = PH_W'(HALF - 1);
  localparam logic [COLS-1:0] ColReset = {1'b1, {(COLS - 1){1'b0}}};

  // Mirrored mode also drives the column reflected about the centre; the middle
  // phase of an odd-width matrix collapses onto a single bit.
  function automatic logic [COLS-1:0] pattern(input logic [PH_W-1:0] ph, input logic mir);
    logic [COLS-1:0] p;
    for (int i = 0; i < COLS; i++) begin
      p[i] = (i == int'(COLS - 1) - int'(ph)) || (mir && (i == int'(ph)));
    end
    return p;
  endfunction

`ifdef COLUMN_SCANNER_GHOST_BLANK_EN
  typedef enum logic {StShow, StBlank} state_e;
  state_e state_q, state_d;
`endif

  logic [PH_W-1:0]    phase_q, phase_d, phase_nxt, last_phase;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mirror_q, mirror_d, mirror_nxt;
  logic [COLS-1:0]    col_q, col_d;
  logic               fs_q, fs_d;
  logic               wrap, terminal;

  always_comb begin
    last_phase = mirror_q ? LastHalf : LastFull;
    wrap       = (phase_q == last_phase);
    terminal   = (cnt_q >= dwell);
    phase_nxt  = wrap ? '0 : phase_q + PH_W'(1);
    mirror_nxt = wrap ? mirror : mirror_q;

    phase_d  = phase_q;
    cnt_d    = cnt_q;
    mirror_d = mirror_q;
    col_d    = col_q;
    fs_d     = 1'b0;
`ifdef COLUMN_SCANNER_GHOST_BLANK_EN
    state_d  = state_q;
`endif

    if (enable) begin
`ifdef COLUMN_SCANNER_GHOST_BLANK_EN
      if (state_q == StBlank) begin
        state_d = StShow;
        col_d   = pattern(phase_q, mirror_q);
        // Phase 0 is only ever reached through a wrap, so this marks a new frame.
        fs_d    = (phase_q == '0);
      end else if (terminal) begin
        cnt_d    = '0;
        phase_d  = phase_nxt;
        mirror_d = mirror_nxt;
        state_d  = StBlank;
        col_d    = '0;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
`else
      if (terminal) begin
        cnt_d    = '0;
        phase_d  = phase_nxt;
        mirror_d = mirror_nxt;
        col_d    = pattern(phase_nxt, mirror_nxt);
        fs_d     = wrap;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q  <= '0;
      cnt_q    <= '0;
      mirror_q <= 1'b0;
      col_q    <= ColReset;
      fs_q     <= 1'b0;
`ifdef COLUMN_SCANNER_GHOST_BLANK_EN
      state_q  <= StShow;
`endif
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      mirror_q <= mirror_d;
      col_q    <= col_d;
      fs_q     <= fs_d;
`ifdef COLUMN_SCANNER_GHOST_BLANK_EN
      state_q  <= state_d;
`endif
    end
  end

  assign col         = col_q;
  assign phase       = phase_q;
  assign frame_start = fs_q;

endmodule
